register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Architectural integer register file for the RV32I core.
- It is the responder side of the decoder's operand interface. It answers regA_add/regB_add with dataA/dataB in the same cycle and accepts the retire-stage write addressed by the decoder's wrAddr.
- It adds a write-through bypass so that a write and a read of the same register in one cycle return the new value.
- After reset it runs a sequential clear sweep, and signals busy while the sweep is in progress.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- BYPASS, 1, 1 enables write-to-read forwarding in the same cycle; 0 makes reads return the stored value only.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- regA_add  in  5  read address, port A (from decoder).
- regB_add  in  5  read address, port B (from decoder).
- dataA  out  DATA_WIDTH  read data, port A; combinational.
- dataB  out  DATA_WIDTH  read data, port B; combinational.
- we  in  1  write enable (from retire stage).
- wrAddr  in  5  write address (the decoder's lock-queue head).
- wrData  in  DATA_WIDTH  write data.
- busy  out  1  clear sweep in progress; the pipeline must stall while this is 1.
- wr_drop  out  1  registered one-cycle pulse: a write was discarded because busy was 1.

Behaviour:
- Storage: 31 registers, x1..x31. x0 is not stored. Reads of address 0 always return 0, and writes to address 0 are ignored without raising wr_drop.
- State machine, 2 states: CLEAR and READY.
- Reset (reset==0 sampled at a clock edge):
  - state<=CLEAR, idx<=1, wr_drop<=0.
  - Register contents are untouched at that edge. The sweep clears them afterwards.
- CLEAR:
  - Each cycle, reg[idx]<=0 and idx<=idx+1.
  - When reg[31] is cleared (idx==31), next state is READY.
  - Timing: if reset is released at edge E0, registers 1..31 are cleared on edges E1..E31, and busy is 0 from E31 onward.
  - busy=1 throughout CLEAR, including while reset is held low.
- Reads during CLEAR: dataA=dataB=0 regardless of address. No partially cleared values are visible.
- Writes during CLEAR: if we==1 and wrAddr!=0, the write is discarded and wr_drop is 1 in the following cycle. The sweep is not altered.
- READY:
  - busy=0.
  - If we==1 and wrAddr!=0, reg[wrAddr]<=wrData at the edge.
  - State stays READY until reset.
- Reset mid-sweep: the sweep restarts at idx=1, and busy stays 1 without a gap.
- Reset in READY: the state machine re-enters CLEAR, and all registers read 0 from that point.
- Read path in READY:
  - If addr==0, data=0.
  - Else if BYPASS==1, we==1 and wrAddr==addr, data=wrData.
  - Else data=reg[addr].
  - Ports A and B are independent. Both may hit the bypass in the same cycle.
- Latency: read is 0 cycles (combinational). Write is visible via stored data from the next cycle, or in the same cycle via the bypass.
- wr_drop: registered, reset value 0, high for exactly one cycle per discarded write.
- Reset values: busy=1, wr_drop=0, dataA=dataB=0 (forced by CLEAR).
- Widths: no arithmetic beyond the 5-bit idx. idx must not wrap; the transition to READY happens at idx==31.

Test Plan:
- Reset low for 3 cycles, then released -> busy=1 for exactly 31 cycles after release; dataA=0 for regA_add=5 throughout; busy=0 on cycle 32.
- READY: write x7=0xDEADBEEF, then read regA_add=7 the next cycle -> dataA=0xDEADBEEF. Write x0=0x1234, read regB_add=0 -> dataB=0 and wr_drop=0.
- Bypass: x3 holds 0x11, then same cycle we=1, wrAddr=3, wrData=0x22, regA_add=regB_add=3 -> dataA=dataB=0x22. With BYPASS=0 -> both 0x11, and 0x22 is visible the next cycle.
- Write during sweep: we=1, wrAddr=9, wrData=0x55 at cycle 10 of CLEAR -> wr_drop=1 for one cycle; after READY, x9 reads 0.
- Reset mid-sweep: reset pulsed low for 1 cycle at cycle 20 of CLEAR -> busy stays 1 and deasserts 31 cycles after the second release.
- Reset from READY with x31=0xFFFFFFFF -> busy=1 immediately, x31 reads 0 after the sweep completes.

Source files
------------

// File: rtl/register_bank.sv
// RV32I integer register file: x1..x31 with combinational dual read, one write port,
// optional same-cycle write forwarding, and a post-reset clear sweep that holds busy high.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            regA_add,
    input  logic [4:0]            regB_add,
    output logic [DATA_WIDTH-1:0] dataA,
    output logic [DATA_WIDTH-1:0] dataB,
    input  logic                  we,
    input  logic [4:0]            wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  busy,
    output logic                  wr_drop
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t     state_reg;
    logic [4:0] idx_reg;
    logic       busy_reg;
    logic       wr_drop_reg;
    logic       wr_req;

    // Writes to x0 are never real requests, so they neither store nor count as dropped.
    assign wr_req = we && (wrAddr != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= CLEAR;
            idx_reg     <= 5'd1;
            busy_reg    <= 1'b1;
            wr_drop_reg <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    wr_drop_reg <= wr_req;
                    if (idx_reg == 5'd31) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg + 5'd1;
                    end
                end
                default: begin
                    wr_drop_reg <= 1'b0;
                end
            endcase
        end
    end

    // busy also covers the cycles where reset is held low but not yet sampled.
    assign busy    = busy_reg | ~reset;
    assign wr_drop = wr_drop_reg;

    logic [DATA_WIDTH-1:0] rd_table [0:31];

    assign rd_table[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic                  clr_hit;
            logic                  wr_hit;
            logic [DATA_WIDTH-1:0] q_reg;

            assign clr_hit = reset && (state_reg == CLEAR) && (idx_reg == 5'(gi));
            assign wr_hit  = reset && (state_reg == READY) && wr_req && (wrAddr == 5'(gi));

            always_ff @(posedge clk) begin
                if (clr_hit) begin
                    q_reg <= '0;
                end else if (wr_hit) begin
                    q_reg <= wrData;
                end
            end

            assign rd_table[gi] = q_reg;
        end
    endgenerate

    logic [4:0]            rd_addr [0:1];
    logic [DATA_WIDTH-1:0] rd_data [0:1];

    assign rd_addr[0] = regA_add;
    assign rd_addr[1] = regB_add;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic                  fwd;
            logic [DATA_WIDTH-1:0] q;

            assign fwd = (BYPASS != 0) && we && (wrAddr == rd_addr[gi]);

            // Nothing stored is visible while busy, so a half-finished sweep never leaks out.
            always_comb begin
                q = '0;
                if (!busy && (rd_addr[gi] != 5'd0)) begin
                    q = fwd ? wrData : rd_table[rd_addr[gi]];
                end
            end

            assign rd_data[gi] = q;
        end
    endgenerate

    assign dataA = rd_data[0];
    assign dataB = rd_data[1];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: forwarding and stored-only instances side by side,
// directed vector table, sweep/reset sequences and randomized traffic against a model.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  regA_add, regB_add, wrAddr;
    logic [31:0] wrData;
    logic [31:0] dataA1, dataB1, dataA0, dataB0;
    logic        busy1, busy0, drop1, drop0;

    always #5 clk = ~clk;

    register_bank #(.DATA_WIDTH(32), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .regA_add(regA_add), .regB_add(regB_add),
        .dataA(dataA1), .dataB(dataB1), .we(we), .wrAddr(wrAddr), .wrData(wrData),
        .busy(busy1), .wr_drop(drop1)
    );

    register_bank #(.DATA_WIDTH(32), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset), .regA_add(regA_add), .regB_add(regB_add),
        .dataA(dataA0), .dataB(dataB0), .we(we), .wrAddr(wrAddr), .wrData(wrData),
        .busy(busy0), .wr_drop(drop0)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural values plus how many sweep edges remain.
    logic [31:0] mem [32];
    int          sweep_left;
    logic        exp_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic exp_busy();
        return (!reset) || (sweep_left > 0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (exp_busy() || a == 5'd0) return 32'h0;
        if (byp && we && wrAddr == a) return wrData;
        return mem[a];
    endfunction

    // Check outputs for the current inputs, then advance one edge and update the model.
    task automatic cycle();
        #1;
        chk("busy_byp",    {31'b0, busy1}, {31'b0, exp_busy()});
        chk("busy_nobyp",  {31'b0, busy0}, {31'b0, exp_busy()});
        chk("dataA_byp",   dataA1, exp_rd(regA_add, 1'b1));
        chk("dataB_byp",   dataB1, exp_rd(regB_add, 1'b1));
        chk("dataA_nobyp", dataA0, exp_rd(regA_add, 1'b0));
        chk("dataB_nobyp", dataB0, exp_rd(regB_add, 1'b0));
        chk("drop_byp",    {31'b0, drop1}, {31'b0, exp_drop});
        chk("drop_nobyp",  {31'b0, drop0}, {31'b0, exp_drop});
        @(posedge clk);
        if (!reset) begin
            sweep_left = 31;
            exp_drop   = 1'b0;
        end else if (sweep_left > 0) begin
            mem[32 - sweep_left] = 32'h0;
            exp_drop   = we && (wrAddr != 5'd0);
            sweep_left = sweep_left - 1;
        end else begin
            exp_drop = 1'b0;
            if (we && wrAddr != 5'd0) mem[wrAddr] = wrData;
        end
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea1;
        logic [31:0] eb1;
        logic [31:0] ea0;
        logic [31:0] eb0;
    } vec_t;

    vec_t vecs [8];
    int   n;

    initial begin
        // Expected values assume a freshly cleared bank, with x9's write dropped during the sweep.
        vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd3,  32'h11,       5'd3,  5'd7,  32'h11,       32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd3,  32'h22,       5'd3,  5'd3,  32'h22,       32'h22,       32'h11,       32'h11};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd9,  32'h22,       32'h0,        32'h22,       32'h0};
        vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        sweep_left = 31;
        exp_drop   = 1'b0;
        reset      = 1'b0;
        we         = 1'b0;
        wrAddr     = 5'd0;
        wrData     = 32'h0;
        regA_add   = 5'd0;
        regB_add   = 5'd0;

        // Reset low for three edges, then count the busy window after release.
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset    = 1'b1;
        regA_add = 5'd5;
        n = 0;
        while (busy1 && n < 100) begin
            if (n == 11) chk("drop_after_sweep_write", {31'b0, drop1}, 32'h1);
            we     = (n == 10);
            wrAddr = (n == 10) ? 5'd9 : 5'd0;
            wrData = (n == 10) ? 32'h55 : 32'h0;
            cycle();
            n++;
        end
        chk("sweep_len", n, 31);
        we = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (i == 3) chk("x0_write_no_drop", {31'b0, drop1}, 32'h0);
            we       = vecs[i].we;
            wrAddr   = vecs[i].wa;
            wrData   = vecs[i].wd;
            regA_add = vecs[i].ra;
            regB_add = vecs[i].rb;
            #1;
            chk($sformatf("tbl%0d_A_byp", i),   dataA1, vecs[i].ea1);
            chk($sformatf("tbl%0d_B_byp", i),   dataB1, vecs[i].eb1);
            chk($sformatf("tbl%0d_A_nobyp", i), dataA0, vecs[i].ea0);
            chk($sformatf("tbl%0d_B_nobyp", i), dataB0, vecs[i].eb0);
            cycle();
        end

        // Reset from READY with x31 populated, then a one-cycle reset pulse mid-sweep.
        we       = 1'b0;
        reset    = 1'b0;
        regA_add = 5'd31;
        regB_add = 5'd9;
        #1;
        chk("busy_immediate", {31'b0, busy1}, 32'h1);
        chk("x31_hidden",     dataA1, 32'h0);
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        n = 0;
        while (busy1 && n < 100) begin
            cycle();
            n++;
        end
        chk("resweep_len", n, 31);
        #1;
        chk("x31_cleared", dataA1, 32'h0);
        chk("x9_cleared",  dataB1, 32'h0);
        cycle();

        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 99) != 0);
            we     = 1'($urandom_range(0, 1));
            wrAddr = 5'($urandom_range(0, 31));
            wrData = $urandom;
            regA_add = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
            regB_add = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
